// File: rtl/ika9958_rcc_gen.sv
// Reset-and-clock-control generator for IKA9958.
// Derives the phiA/phiL clock-enable strobes and the CPUCLK/DLCLK pin clocks
// from a mod-12 phase counter, and turns the external /RESET pin into a
// synchronized, phiL-aligned, stretched internal reset.
module ika9958_rcc_gen #(
    parameter int unsigned RST_STRETCH = 16
) (
    input  logic       i_EMUCLK,
    input  logic       i_RST,
    input  logic       i_RESET_n,
    output logic       o_PHIA_PCEN,
    output logic       o_PHIA_NCEN,
    output logic       o_PHIL_PCEN,
    output logic       o_PHIL_NCEN,
    output logic       o_CPUCLK,
    output logic       o_DLCLK,
    output logic       o_HRST_n,
    output logic [3:0] o_PHASE
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned CNT_LAST = 11;
    localparam int unsigned SC_W     = 8;

    // Only 1..255 fits the stretch counter and produces a real stretch.
    if (RST_STRETCH == 0 || RST_STRETCH > 255) begin : g_bad_stretch
        $error("ika9958_rcc_gen: RST_STRETCH must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_COUNT = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic phia_pcen_q, phia_pcen_d;
    logic phia_ncen_q, phia_ncen_d;
    logic phil_pcen_q, phil_pcen_d;
    logic phil_ncen_q, phil_ncen_d;
    logic cpuclk_q,    cpuclk_d;
    logic dlclk_q,     dlclk_d;

    logic s1_q;
    logic s2_q;

    state_t          state_q;
    logic [SC_W-1:0] sc_q;
    logic [SC_W-1:0] sc_inc;
    logic            hrst_n_q;

    // Next phase value and the strobe/pin-clock decode of that next value,
    // so each registered output lines up with the counter value it decodes.
    always_comb begin
        cnt_d       = (cnt_q == CNT_W'(CNT_LAST)) ? '0 : cnt_q + CNT_W'(1);
        phia_pcen_d = ~cnt_d[0];
        phia_ncen_d =  cnt_d[0];
        phil_pcen_d = (cnt_d[1:0] == 2'd1);
        phil_ncen_d = (cnt_d[1:0] == 2'd3);
        dlclk_d     = ~cnt_d[1];
        case (cnt_d)
            4'd0, 4'd1, 4'd2,
            4'd6, 4'd7, 4'd8: cpuclk_d = 1'b1;
            default:          cpuclk_d = 1'b0;
        endcase
    end

    // Phase counter and registered strobes; reset holds everything at 0.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            cnt_q       <= '0;
            phia_pcen_q <= 1'b0;
            phia_ncen_q <= 1'b0;
            phil_pcen_q <= 1'b0;
            phil_ncen_q <= 1'b0;
            cpuclk_q    <= 1'b0;
            dlclk_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            phia_pcen_q <= phia_pcen_d;
            phia_ncen_q <= phia_ncen_d;
            phil_pcen_q <= phil_pcen_d;
            phil_ncen_q <= phil_ncen_d;
            cpuclk_q    <= cpuclk_d;
            dlclk_q     <= dlclk_d;
        end
    end

    // Two-flop synchronizer for the asynchronous /RESET pin.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= i_RESET_n;
            s2_q <= s1_q;
        end
    end

    assign sc_inc = sc_q + SC_W'(1);

    // Stretch FSM: release is counted in phiL falling strobes, assertion is
    // immediate once the synced pin drops.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state_q  <= ST_HOLD;
            sc_q     <= '0;
            hrst_n_q <= 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    hrst_n_q <= 1'b0;
                    if (s2_q) begin
                        state_q <= ST_COUNT;
                        sc_q    <= '0;
                    end
                end
                ST_COUNT: begin
                    hrst_n_q <= 1'b0;
                    if (!s2_q) begin
                        state_q <= ST_HOLD;
                        sc_q    <= '0;
                    end else if (phil_ncen_q) begin
                        sc_q <= sc_inc;
                        if (sc_inc == SC_W'(RST_STRETCH)) begin
                            state_q  <= ST_RUN;
                            hrst_n_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!s2_q) begin
                        state_q  <= ST_HOLD;
                        sc_q     <= '0;
                        hrst_n_q <= 1'b0;
                    end else begin
                        hrst_n_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_HOLD;
                    sc_q     <= '0;
                    hrst_n_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_PHIA_PCEN = phia_pcen_q;
    assign o_PHIA_NCEN = phia_ncen_q;
    assign o_PHIL_PCEN = phil_pcen_q;
    assign o_PHIL_NCEN = phil_ncen_q;
    assign o_CPUCLK    = cpuclk_q;
    assign o_DLCLK     = dlclk_q;
    assign o_HRST_n    = hrst_n_q;
    assign o_PHASE     = cnt_q;

endmodule

// File: tb/tb_ika9958_rcc_gen.sv
// Directed bench for ika9958_rcc_gen: two instances (stretch 4 and 1) share
// the same clock, reset and /RESET pin stimulus.
module tb_ika9958_rcc_gen;

    logic clk;
    logic rst;
    logic pin_n;

    logic pa4, na4, pl4, nl4, cpu4, dl4, hr4;
    logic [3:0] ph4;
    logic pa1, na1, pl1, nl1, cpu1, dl1, hr1;
    logic [3:0] ph1;

    int vec;
    int errs;

    ika9958_rcc_gen #(.RST_STRETCH(4)) u_dut4 (
        .i_EMUCLK    (clk),
        .i_RST       (rst),
        .i_RESET_n   (pin_n),
        .o_PHIA_PCEN (pa4),
        .o_PHIA_NCEN (na4),
        .o_PHIL_PCEN (pl4),
        .o_PHIL_NCEN (nl4),
        .o_CPUCLK    (cpu4),
        .o_DLCLK     (dl4),
        .o_HRST_n    (hr4),
        .o_PHASE     (ph4)
    );

    ika9958_rcc_gen #(.RST_STRETCH(1)) u_dut1 (
        .i_EMUCLK    (clk),
        .i_RST       (rst),
        .i_RESET_n   (pin_n),
        .o_PHIA_PCEN (pa1),
        .o_PHIA_NCEN (na1),
        .o_PHIL_PCEN (pl1),
        .o_PHIL_NCEN (nl1),
        .o_CPUCLK    (cpu1),
        .o_DLCLK     (dl1),
        .o_HRST_n    (hr1),
        .o_PHASE     (ph1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (vectors=%0d)", vec);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        pin_n = 1'b1;
        repeat (3) step();
        vec++;
        if ({pa4, na4, pl4, nl4, cpu4, dl4, hr4, ph4} !== 11'd0) begin
            errs++;
            $display("FAIL reset_dut4: got %b expected 0", {pa4, na4, pl4, nl4, cpu4, dl4, hr4, ph4});
        end
        vec++;
        if ({pa1, na1, pl1, nl1, cpu1, dl1, hr1, ph1} !== 11'd0) begin
            errs++;
            $display("FAIL reset_dut1: got %b expected 0", {pa1, na1, pl1, nl1, cpu1, dl1, hr1, ph1});
        end
    endtask

    // Releases i_RST (pin high) and checks 24 cycles of phase, strobes,
    // pin clocks and the stretch release of both instances.
    task automatic check_release_sequence(input string tag);
        logic [5:0] exp_s;
        int p;
        rst = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            step();
            p = k % 12;
            exp_s = {(p % 2) == 0, (p % 2) == 1, (p % 4) == 1, (p % 4) == 3,
                     (p % 6) < 3, (p % 4) < 2};
            vec++;
            if (ph4 !== 4'(p) || ph1 !== 4'(p)) begin
                errs++;
                $display("FAIL %s_phase k=%0d: got %0d/%0d expected %0d", tag, k, ph4, ph1, p);
            end
            vec++;
            if ({pa4, na4, pl4, nl4, cpu4, dl4} !== exp_s) begin
                errs++;
                $display("FAIL %s_strobes4 k=%0d: got %b expected %b", tag, k, {pa4, na4, pl4, nl4, cpu4, dl4}, exp_s);
            end
            vec++;
            if ({pa1, na1, pl1, nl1, cpu1, dl1} !== exp_s) begin
                errs++;
                $display("FAIL %s_strobes1 k=%0d: got %b expected %b", tag, k, {pa1, na1, pl1, nl1, cpu1, dl1}, exp_s);
            end
            vec++;
            if ({hr4, hr1} !== {k >= 16, k >= 4}) begin
                errs++;
                $display("FAIL %s_hrst k=%0d: got %b expected %b", tag, k, {hr4, hr1}, {k >= 16, k >= 4});
            end
        end
    endtask

    task automatic wait_phase(input logic [3:0] target, input string tag);
        int n;
        n = 0;
        while (ph4 !== target && n < 12) begin
            step();
            n++;
        end
        vec++;
        if (ph4 !== target) begin
            errs++;
            $display("FAIL %s_wait_phase: got %0d expected %0d", tag, ph4, target);
        end
    endtask

    // Releases the pin at phase 8: s2 rises two cycles later and the FSM
    // starts counting at phase 11, so the 4th counted strobe lands on
    // phase 11 and o_HRST_n rises at phase 0.
    task automatic release_stretch(input string tag);
        wait_phase(4'd8, tag);
        pin_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            vec++;
            if ({hr4, hr1} !== {i >= 16, i >= 4}) begin
                errs++;
                $display("FAIL %s_stretch i=%0d: got %b expected %b", tag, i, {hr4, hr1}, {i >= 16, i >= 4});
            end
        end
        vec++;
        if (ph4 !== 4'd0) begin
            errs++;
            $display("FAIL %s_rise_phase: got %0d expected 0", tag, ph4);
        end
    endtask

    task automatic test_phase();
        check_release_sequence("phase");
    endtask

    task automatic test_run_reassert();
        pin_n = 1'b0;
        step();
        step();
        vec++;
        if ({hr4, hr1} !== 2'b11) begin
            errs++;
            $display("FAIL run_reassert_early: got %b expected 11", {hr4, hr1});
        end
        step();
        vec++;
        if ({hr4, hr1} !== 2'b00) begin
            errs++;
            $display("FAIL run_reassert_low: got %b expected 00", {hr4, hr1});
        end
    endtask

    task automatic test_stretch();
        release_stretch("stretch");
    endtask

    task automatic test_count_reassert();
        pin_n = 1'b0;
        repeat (3) step();
        wait_phase(4'd8, "count_pre");
        pin_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            vec++;
            if (hr4 !== 1'b0) begin
                errs++;
                $display("FAIL count_partial i=%0d: got %b expected 0", i, hr4);
            end
        end
        vec++;
        if (ph4 !== 4'd4) begin
            errs++;
            $display("FAIL count_partial_phase: got %0d expected 4", ph4);
        end
        pin_n = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            step();
            vec++;
            if (hr4 !== 1'b0) begin
                errs++;
                $display("FAIL count_abort j=%0d: got %b expected 0", j, hr4);
            end
        end
        release_stretch("count_restart");
    endtask

    task automatic test_mid_rst();
        wait_phase(4'd7, "mid_rst");
        vec++;
        if ({hr4, hr1} !== 2'b11) begin
            errs++;
            $display("FAIL mid_rst_pre: got %b expected 11", {hr4, hr1});
        end
        rst = 1'b1;
        step();
        vec++;
        if ({pa4, na4, pl4, nl4, cpu4, dl4, hr4, ph4} !== 11'd0) begin
            errs++;
            $display("FAIL mid_rst_dut4: got %b expected 0", {pa4, na4, pl4, nl4, cpu4, dl4, hr4, ph4});
        end
        vec++;
        if ({pa1, na1, pl1, nl1, cpu1, dl1, hr1, ph1} !== 11'd0) begin
            errs++;
            $display("FAIL mid_rst_dut1: got %b expected 0", {pa1, na1, pl1, nl1, cpu1, dl1, hr1, ph1});
        end
        check_release_sequence("mid_rst");
    endtask

    initial begin
        vec   = 0;
        errs  = 0;
        rst   = 1'b1;
        pin_n = 1'b1;
        test_reset();
        test_phase();
        test_run_reassert();
        test_stretch();
        test_count_reassert();
        test_mid_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/ika9958_rcc_gen.md
Name: ika9958_rcc_gen

Overview:
- Reset-and-clock-control generator for IKA9958. It sits directly upstream of the screen-timing stage and drives its phase strobes and its `i_HRST_n` input.
- From a single XTAL-rate clock, it derives the phiA/phiL clock-enable strobes and the CPUCLK/DLCLK pin clocks.
- It synchronizes and stretches the external VDP /RESET pin, producing a phase-aligned internal active-low reset.

Parameters:
- RST_STRETCH, 16: number of phiL periods that `o_HRST_n` stays low after the synced /RESET pin releases. Legal range 1–255.

Ports:
- i_EMUCLK  in  1  XTAL-rate clock (21.477 MHz); the only clock.
- i_RST  in  1  system reset; synchronous, active-high.
- i_RESET_n  in  1  external VDP /RESET pin; asynchronous, active-low.
- o_PHIA_PCEN  out  1  one-cycle strobe, phiA positive edge.
- o_PHIA_NCEN  out  1  one-cycle strobe, phiA negative edge.
- o_PHIL_PCEN  out  1  one-cycle strobe, phiL positive edge.
- o_PHIL_NCEN  out  1  one-cycle strobe, phiL negative edge.
- o_CPUCLK  out  1  XTAL/6 square wave, 50% duty.
- o_DLCLK  out  1  XTAL/4 square wave, 50% duty.
- o_HRST_n  out  1  internal reset to the screen-timing stage; active-low.
- o_PHASE  out  4  phase counter value (0..11), for debug and verification.

Behaviour:

Phase counter
- 4-bit register `cnt`, mod 12 (12 = LCM of 2, 4 and 6).
- i_RST high: `cnt` <= 0.
- Otherwise: `cnt` <= (`cnt` == 11) ? 0 : `cnt` + 1.
- `o_PHASE` = `cnt`.

Strobes and pin clocks
- All are registered, computed from the next value of `cnt`, so each output is valid in the same cycle as the `cnt` value it decodes.
- While i_RST is high, all of them are forced to 0.
- `o_PHIA_PCEN` = 1 when `cnt` is even.
- `o_PHIA_NCEN` = 1 when `cnt` is odd.
- `o_PHIL_PCEN` = 1 when `cnt` mod 4 = 1.
- `o_PHIL_NCEN` = 1 when `cnt` mod 4 = 3.
- `o_CPUCLK` = 1 when `cnt` mod 6 is in {0, 1, 2}.
- `o_DLCLK` = 1 when `cnt` mod 4 is in {0, 1}.
- Consequences:
  - Exactly one of the two phiA strobes is high in every non-reset cycle.
  - The two phiL strobes are never high together, and never in the same cycle as each other's parity partner.

First cycles after i_RST falls
- The cycle in which i_RST is sampled low: `cnt` goes 0 -> 1.
- The next cycle shows `cnt` = 1 with `o_PHIA_NCEN` = 1 and `o_PHIL_PCEN` = 1.
- Strobes are therefore deterministic relative to reset release.

/RESET synchronizer
- Two flip-flops, `s1` and `s2`.
- i_RST forces both to 0 (reset asserted).
- `s2` is the synced pin. Pin-to-`s2` latency is 2 cycles.

Stretch FSM
- States: HOLD, COUNT, RUN. i_RST forces HOLD, stretch counter `sc` = 0, and `o_HRST_n` = 0.
- HOLD:
  - `o_HRST_n` = 0.
  - If `s2` = 1, go to COUNT with `sc` = 0.
- COUNT:
  - `o_HRST_n` = 0.
  - On each cycle with `o_PHIL_NCEN` = 1, `sc` increments.
  - When `sc` reaches RST_STRETCH on a phiL_NCEN cycle, go to RUN; `o_HRST_n` = 1 from the following cycle.
  - If `s2` = 0 at any time, go to HOLD and clear `sc`.
- RUN:
  - `o_HRST_n` = 1.
  - If `s2` = 0, go to HOLD; `o_HRST_n` = 0 from the next cycle (assertion is not phase-aligned).
- `o_HRST_n` rising edge is therefore always the cycle after a phiL_NCEN cycle.
- Pin pulses shorter than 1 cycle may be missed. Any pulse captured by `s2` restarts the full stretch.

Reset mid-operation
- i_RST at any cycle overrides everything: counter, strobes, synchronizer and FSM.
- In the cycle after i_RST is sampled high, all outputs are 0 and `o_PHASE` = 0.

Width rule
- `sc` is 8 bits.
- An RST_STRETCH value outside 1..255 is illegal; an elaboration-time assertion flags it.

Test Plan:
- **Phase sequence:** release i_RST with i_RESET_n = 1 -> `o_PHASE` steps 1, 2, …, 11, 0, 1; `o_PHIA_NCEN` high at phases 1, 3, 5; `o_PHIL_PCEN` high at 1, 5, 9; `o_PHIL_NCEN` high at 3, 7, 11.
- **Pin clocks over 24 cycles:** `o_CPUCLK` pattern 111000 repeats 4×; `o_DLCLK` pattern 1100 repeats 6×; phiA strobes are mutually exclusive and one is high every cycle.
- **Stretch timing, RST_STRETCH = 4:** i_RESET_n low then high -> `o_HRST_n` rises exactly one cycle after the 4th `o_PHIL_NCEN` counted after `s2` goes high, i.e. at a phase-0 cycle.
- **/RESET re-assert:** i_RESET_n re-asserted during COUNT after 2 strobes -> `o_HRST_n` stays 0; after release, a full 4-strobe stretch restarts. Re-asserted in RUN -> `o_HRST_n` = 0 three cycles after the pin falls.
- **i_RST mid-run:** i_RST pulsed for 1 cycle at phase 7 with `o_HRST_n` = 1 -> next cycle all outputs 0 and `o_PHASE` = 0; the sequence restarts at phase 1 and the stretch repeats.
- **Boundary, RST_STRETCH = 1:** `o_HRST_n` rises after the first `o_PHIL_NCEN` following `s2` = 1.
